// File: rtl/jt49_noise_lfsr.sv
// jt49_noise_lfsr: divided-tick LFSR noise source for JT49-style PSGs.
// Define JT49_NOISE_PERIODIC_EN to honour mode (SN76489-style periodic noise).
module jt49_noise_lfsr #(
  parameter int PW  = 5,
  parameter int LW  = 17,
  parameter int TAP = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [PW-1:0] period,
  input  logic          mode,
  input  logic          restart,
  output logic          noise,
  output logic          shift,
  output logic [LW-1:0] lfsr
);
  logic [PW-1:0] count;
  logic [PW:0]   cnt_nx, per_eff;
  logic          div, last_div, up, tick, zero, fb;
  assign per_eff = period == '0 ? (PW+1)'(1) : {1'b0, period};
  assign cnt_nx  = {1'b0, count} + (PW+1)'(1);
  assign tick    = cnt_nx >= per_eff;
  assign up      = div & ~last_div;
  assign zero    = lfsr == '0;
  // the zero term pulls the register out of the all-zero state in either mode
`ifdef JT49_NOISE_PERIODIC_EN
  assign fb = mode ? (lfsr[0] | zero) : (lfsr[0] ^ lfsr[TAP] ^ zero);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign fb = lfsr[0] ^ lfsr[TAP] ^ zero;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count    <= '0;
      div      <= 1'b0;
      last_div <= 1'b0;
      lfsr     <= '0;
      noise    <= 1'b1;
      shift    <= 1'b0;
    end else if (restart) begin
      count    <= '0;
      div      <= 1'b0;
      last_div <= 1'b0;
      lfsr     <= '0;
      shift    <= 1'b0;
    end else begin
      shift <= cen & up;
      if (cen) begin
        count    <= tick ? '0 : cnt_nx[PW-1:0];
        div      <= div ^ tick;
        last_div <= div;
        noise    <= ~lfsr[0];
        if (up) lfsr <= {fb, lfsr[LW-1:1]};
      end
    end
endmodule
